// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: 2-entry skid buffer with the opcode decoded at capture time.
// Optional ALU_ISSUE_PERF_EN adds saturating stall and illegal-issue counters.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [6:0]       out_sel,
  output logic             out_sub,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]      stall_cnt,
  output logic [15:0]      illegal_cnt,
`endif
  output logic             out_illegal
);

  // decoded entry: {illegal, sub, sel[6:0]}
  function automatic logic [8:0] decode(input logic [OP_W-1:0] op);
    logic [8:0] r;
    r = '0;
    case (op)
      OP_W'(0): r[0] = 1'b1;
      OP_W'(1): begin r[1] = 1'b1; r[7] = 1'b1; end
      OP_W'(2): r[2] = 1'b1;
      OP_W'(3): r[3] = 1'b1;
      OP_W'(4): r[4] = 1'b1;
      OP_W'(5): begin r[5] = 1'b1; r[7] = 1'b1; end
      OP_W'(6): begin r[6] = 1'b1; r[7] = 1'b1; end
      default:  r[8] = 1'b1;
    endcase
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [8:0]       out_dec_q, out_dec_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d;
  logic [WIDTH-1:0] skid_b_q, skid_b_d;
  logic [8:0]       skid_dec_q, skid_dec_d;

  logic       in_fire;
  logic       ld_out;
  logic [8:0] in_dec;

  // rst_n gates in_ready so nothing is accepted while reset is held
  assign in_ready = rst_n && !skid_valid_q && !flush;
  assign in_fire  = in_valid && in_ready;
  assign ld_out   = !out_valid_q || out_ready;
  assign in_dec   = decode(in_op);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_dec_d    = out_dec_q;
    skid_valid_d = skid_valid_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_dec_d   = skid_dec_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (ld_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_a_d      = skid_a_q;
        out_b_d      = skid_b_q;
        out_dec_d    = skid_dec_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_a_d     = in_a;
        out_b_d     = in_b;
        out_dec_d   = in_dec;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_a_d     = in_a;
      skid_b_d     = in_b;
      skid_dec_d   = in_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_dec_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_dec_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_dec_q    <= out_dec_d;
      skid_valid_q <= skid_valid_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_dec_q   <= skid_dec_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_sel     = out_dec_q[6:0];
  assign out_sub     = out_dec_q[7];
  assign out_illegal = out_dec_q[8];

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  // counters observe the handshake regardless of flush
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (out_valid_q && out_ready && out_dec_q[8] && (illegal_cnt_q != '1))
      illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a 2-deep FIFO reference model.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_ready, out_valid, out_sub, out_illegal;
  logic [31:0] out_a, out_b;
  logic [6:0]  out_sel;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] illegal_cnt;
  longint      m_stall = 0;
  longint      m_ill = 0;
`endif

  alu_issue_stage #(.WIDTH(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sel(out_sel), .out_sub(out_sub),
`ifdef ALU_ISSUE_PERF_EN
    .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt),
`endif
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_sel(input logic [2:0] op);
    logic [6:0] one;
    one = 7'd1;
    return (op == 3'd7) ? 7'd0 : (one << op);
  endfunction

  function automatic logic exp_sub(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd5) || (op == 3'd6);
  endfunction

  task automatic check_out();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_a", 64'(out_a), 64'(q[0].a));
      check("out_b", 64'(out_b), 64'(q[0].b));
      check("out_sel", 64'(out_sel), 64'(exp_sel(q[0].op)));
      check("out_sub", 64'(out_sub), 64'(exp_sub(q[0].op)));
      check("out_illegal", 64'(out_illegal), 64'(q[0].op == 3'd7));
    end
`ifdef ALU_ISSUE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
`endif
  endtask

  // one clock: drive, check in_ready, advance model at the edge, check outputs
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic ordy, input logic fl);
    logic exp_rdy, pop, push;
    ent_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (q.size() < 2) && !fl;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    pop  = (q.size() > 0) && ordy;
    push = v && exp_rdy;
    e.a = a; e.b = b; e.op = op;
    @(posedge clk);
`ifdef ALU_ISSUE_PERF_EN
    if (q.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (pop && q[0].op == 3'd7 && m_ill < 64'hFFFF) m_ill++;
`endif
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
    check_out();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 3'd0, ordy, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_a", 64'(out_a), 64'd0);
    check("post_rst_out_sel", 64'(out_sel), 64'd0);
    check_out();

    // streaming
    cycle(1'b1, 32'd5, 32'd3, 3'd1, 1'b1, 1'b0);
    check("stream0_sel", 64'(out_sel), 64'h02);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b1, 1'b0);
    check("stream1_sel", 64'(out_sel), 64'h20);
    cycle(1'b1, 32'd1, 32'hFFFF_FFFF, 3'd6, 1'b1, 1'b0);
    check("stream2_sel", 64'(out_sel), 64'h40);
    check("stream2_sub", 64'(out_sub), 64'd1);
    idle(1'b1);

    // backpressure
    cycle(1'b1, 32'hAAAA_0000, 32'h1, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'hBBBB_0000, 32'h2, 3'd2, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    idle(1'b0);
    check("bp_hold_a", 64'(out_a), 64'hAAAA_0000);
    idle(1'b1);
    check("bp_b_out", 64'(out_a), 64'hBBBB_0000);
    idle(1'b1);

    // illegal opcode
    cycle(1'b1, 32'h10, 32'h20, 3'd7, 1'b0, 1'b0);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_sel", 64'(out_sel), 64'd0);
    check("ill_a", 64'(out_a), 64'h10);
    idle(1'b1);

    // flush with both entries full
    cycle(1'b1, 32'h11, 32'h0, 3'd3, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 32'h0, 3'd4, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 32'h0, 3'd0, 1'b1, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    cycle(1'b1, 32'h44, 32'h5, 3'd1, 1'b1, 1'b0);
    idle(1'b1);

    // async reset mid-stall
    cycle(1'b1, 32'h55, 32'h0, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 32'h0, 3'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
`ifdef ALU_ISSUE_PERF_EN
    m_stall = 0; m_ill = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_rel_in_ready", 64'(in_ready), 64'd1);
    check("arst_rel_out_a", 64'(out_a), 64'd0);
    check_out();

    // 4 stall cycles and 2 illegal entries
    cycle(1'b1, 32'h1, 32'h2, 3'd7, 1'b0, 1'b0);
    cycle(1'b1, 32'h3, 32'h4, 3'd7, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
`ifdef ALU_ISSUE_PERF_EN
    check("perf_stall4", 64'(stall_cnt), 64'd4);
    check("perf_ill2", 64'(illegal_cnt), 64'd2);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
